// File: rtl/line_mem_responder.sv
// Cache-line memory responder: one 128-bit line per request and a programmable
// access latency. Requests are held by the initiator until a one-cycle mem_resp.
module line_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int IDX_BITS    = 8,
    parameter int OFFSET_BITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         protocol_err
);
    localparam int         LINES    = 1 << IDX_BITS;
    localparam int         TOP      = OFFSET_BITS + IDX_BITS;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
    localparam bit         DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_next;
    logic [7:0]          cnt, cnt_next;
    logic                op_write, op_write_next;
    logic [IDX_BITS-1:0] idx, idx_next;
    logic [127:0]        wdata, wdata_next;
    logic                resp_next;
    logic                err_set;
    logic                acc_en;
    logic                acc_write;
    logic [IDX_BITS-1:0] acc_idx;
    logic [127:0]        acc_wdata;
    logic                req;
    logic                both;
    logic [IDX_BITS-1:0] addr_idx;
    logic                unused_addr;
    logic [127:0]        lines [LINES];

    assign req         = mem_read | mem_write;
    assign both        = mem_read & mem_write;
    assign addr_idx    = mem_address[TOP-1:OFFSET_BITS];
    assign unused_addr = ^{mem_address[15:TOP], mem_address[OFFSET_BITS-1:0]};

    // cnt counts BUSY cycles still to go; the access happens on the edge where it would reach zero.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        op_write_next = op_write;
        idx_next      = idx;
        wdata_next    = wdata;
        resp_next     = 1'b0;
        err_set       = 1'b0;
        acc_en        = 1'b0;
        acc_write     = op_write;
        acc_idx       = idx;
        acc_wdata     = wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    op_write_next = mem_write;
                    idx_next      = addr_idx;
                    wdata_next    = mem_wdata;
                    err_set       = both;
                    if (DIRECT) begin
                        acc_en     = 1'b1;
                        acc_write  = mem_write;
                        acc_idx    = addr_idx;
                        acc_wdata  = mem_wdata;
                        resp_next  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    err_set = both | (mem_write != op_write);
                    if (cnt == 8'd1) begin
                        acc_en     = 1'b1;
                        resp_next  = 1'b1;
                        state_next = RESP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_write     <= 1'b0;
            idx          <= '0;
            wdata        <= '0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            protocol_err <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            op_write <= op_write_next;
            idx      <= idx_next;
            wdata    <= wdata_next;
            mem_resp <= resp_next;
            if (acc_en && !acc_write) begin
                mem_rdata <= lines[acc_idx];
            end
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // The line array is never reset; the rst_n gate stops a held request writing during reset.
    always_ff @(posedge clk) begin
        if (rst_n && acc_en && acc_write) begin
            lines[acc_idx] <= acc_wdata;
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 instance for the back-to-back minimum-latency case.
module tb_line_mem_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         protocol_err;
    logic         r1_read, r1_write;
    logic [15:0]  r1_address;
    logic [127:0] r1_wdata;
    logic         r1_resp;
    logic [127:0] r1_rdata;
    logic         r1_err;

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model [int];
    logic [127:0] last_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_responder #(.LATENCY(4), .IDX_BITS(8), .OFFSET_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .protocol_err(protocol_err)
    );

    line_mem_responder #(.LATENCY(1), .IDX_BITS(8), .OFFSET_BITS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(r1_read), .mem_write(r1_write),
        .mem_address(r1_address), .mem_wdata(r1_wdata), .mem_resp(r1_resp),
        .mem_rdata(r1_rdata), .protocol_err(r1_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int key(input bit sel, input logic [15:0] addr);
        return (sel ? 256 : 0) + int'(addr[11:4]);
    endfunction

    task automatic set_req(input bit sel, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [127:0] wd);
        if (sel) begin
            r1_read = rd; r1_write = wr; r1_address = addr; r1_wdata = wd;
        end else begin
            mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
        end
    endtask

    // Drives one held request; returns the response cycle relative to acceptance
    // (-1 on timeout), its absolute cycle, the read line and mem_resp one cycle later.
    task automatic run_txn(input bit sel, input bit wr, input bit both,
                           input logic [15:0] addr, input logic [127:0] wd,
                           output int rel, output int abs_cyc,
                           output logic [127:0] rdata, output logic resp_next);
        logic rd_l, wr_l;
        int   k;
        rd_l = !wr || both;
        wr_l = wr || both;
        k = key(sel, addr);
        if (wr_l) model[k] = wd;
        else exp_q.push_back(model[k]);
        set_req(sel, rd_l, wr_l, addr, wd);
        rel = -1; abs_cyc = -1; rdata = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 2) set_req(sel, rd_l, wr_l, ~addr, ~wd);
            if (sel ? r1_resp : mem_resp) begin
                rel = c; abs_cyc = cyc; rdata = sel ? r1_rdata : mem_rdata;
                break;
            end
        end
        set_req(sel, 1'b0, 1'b0, 16'($urandom), rand128());
        @(posedge clk); #1;
        resp_next = sel ? r1_resp : mem_resp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0", mem_resp); end
        total++; if (mem_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", mem_rdata); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", protocol_err); end
        total++; if (r1_resp !== 1'b0) begin bad++; $display("FAIL rst_resp1 got=%b exp=0", r1_resp); end
        total++; if (r1_rdata !== '0) begin bad++; $display("FAIL rst_rdata1 got=%h exp=0", r1_rdata); end
        total++; if (r1_err !== 1'b0) begin bad++; $display("FAIL rst_err1 got=%b exp=0", r1_err); end
        rst_n = 1'b1;
        last_rd = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int rel, abs_c; logic [127:0] rd, ex; logic rn;
        run_txn(0, 1, 0, 16'h0040, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, rel, abs_c, rd, rn);
        total++; if (rel !== 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", rel); end
        total++; if (rn !== 1'b0) begin bad++; $display("FAIL wr_pulse_width got=%b exp=0", rn); end
        total++; if (mem_rdata !== last_rd) begin bad++; $display("FAIL wr_keeps_rdata got=%h exp=%h", mem_rdata, last_rd); end
        run_txn(0, 0, 0, 16'h004C, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rel !== 4) begin bad++; $display("FAIL rd_latency got=%0d exp=4", rel); end
        total++; if (rn !== 1'b0) begin bad++; $display("FAIL rd_pulse_width got=%b exp=0", rn); end
        total++; if (rd !== ex) begin bad++; $display("FAIL rd_offset got=%h exp=%h", rd, ex); end
        run_txn(0, 0, 0, 16'hF04C, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL rd_alias got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_arbiter_alternate();
        int rel, ta, tb; logic [127:0] rd, ex; logic rn;
        run_txn(0, 1, 0, 16'h0100, rand128(), rel, ta, rd, rn);
        run_txn(0, 0, 0, 16'h0100, '0, rel, ta, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL arb_a_read got=%h exp=%h", rd, ex); end
        run_txn(0, 1, 0, 16'h0200, rand128(), rel, tb, rd, rn);
        total++; if (tb - ta !== 5) begin bad++; $display("FAIL arb_b_spacing got=%0d exp=5", tb - ta); end
        run_txn(0, 0, 0, 16'h0200, '0, rel, ta, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL arb_a_gets_b got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_abort();
        int rel, abs_c, seen; logic [127:0] rd, ex; logic rn;
        run_txn(0, 1, 0, 16'h0300, rand128(), rel, abs_c, rd, rn);
        seen = 0;
        set_req(0, 1'b1, 1'b0, 16'h0300, '0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (mem_resp) seen++;
            if (c == 2) set_req(0, 1'b0, 1'b0, 16'h0300, '0);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_rd_resp got=%0d exp=0", seen); end
        total++; if (mem_rdata !== last_rd) begin bad++; $display("FAIL abort_rd_rdata got=%h exp=%h", mem_rdata, last_rd); end
        seen = 0;
        set_req(0, 1'b0, 1'b1, 16'h0300, rand128());
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (mem_resp) seen++;
            if (c == 3) set_req(0, 1'b0, 1'b0, 16'h0300, '0);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_wr_resp got=%0d exp=0", seen); end
        run_txn(0, 0, 0, 16'h0300, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL abort_wr_line got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_both_high();
        int rel, abs_c; logic [127:0] rd, ex, pat; logic rn;
        pat = {32{4'hA}};
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", protocol_err); end
        run_txn(0, 1, 1, 16'h0400, pat, rel, abs_c, rd, rn);
        total++; if (rel !== 4) begin bad++; $display("FAIL both_latency got=%0d exp=4", rel); end
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL both_err got=%b exp=1", protocol_err); end
        run_txn(0, 0, 0, 16'h0400, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL both_line got=%h exp=%h", rd, ex); end
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", protocol_err); end
    endtask

    task automatic test_reset_mid_write();
        int rel, abs_c; logic [127:0] rd, ex; logic rn;
        run_txn(0, 1, 0, 16'h0500, rand128(), rel, abs_c, rd, rn);
        set_req(0, 1'b0, 1'b1, 16'h0500, rand128());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL mid_rst_resp got=%b exp=0", mem_resp); end
        total++; if (mem_rdata !== '0) begin bad++; $display("FAIL mid_rst_rdata got=%h exp=0", mem_rdata); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", protocol_err); end
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = '0;
        run_txn(0, 0, 0, 16'h0500, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rel !== 4) begin bad++; $display("FAIL post_rst_latency got=%0d exp=4", rel); end
        total++; if (rd !== ex) begin bad++; $display("FAIL post_rst_line got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_op_change();
        int rel, abs_c; logic [127:0] rd, ex; logic rn;
        run_txn(0, 1, 0, 16'h0600, rand128(), rel, abs_c, rd, rn);
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL opchg_err_before got=%b exp=0", protocol_err); end
        exp_q.push_back(model[key(0, 16'h0600)]);
        set_req(0, 1'b1, 1'b0, 16'h0600, '0);
        rel = -1; rd = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 2) set_req(0, 1'b0, 1'b1, 16'h0600, rand128());
            if (mem_resp) begin rel = c; rd = mem_rdata; break; end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rel !== 4) begin bad++; $display("FAIL opchg_latency got=%0d exp=4", rel); end
        total++; if (rd !== ex) begin bad++; $display("FAIL opchg_rdata got=%h exp=%h", rd, ex); end
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL opchg_err got=%b exp=1", protocol_err); end
        run_txn(0, 0, 0, 16'h0600, '0, rel, abs_c, rd, rn);
        ex = exp_q.pop_front(); last_rd = ex;
        total++; if (rd !== ex) begin bad++; $display("FAIL opchg_no_write got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_latency_one();
        int rel, t1, t2; logic [127:0] rd, ex; logic rn;
        run_txn(1, 1, 0, 16'h0000, rand128(), rel, t1, rd, rn);
        total++; if (rel !== 1) begin bad++; $display("FAIL l1_wr_latency got=%0d exp=1", rel); end
        run_txn(1, 1, 0, 16'h0010, rand128(), rel, t1, rd, rn);
        run_txn(1, 0, 0, 16'h0000, '0, rel, t1, rd, rn);
        ex = exp_q.pop_front();
        total++; if (rel !== 1) begin bad++; $display("FAIL l1_rd_latency got=%0d exp=1", rel); end
        total++; if (rd !== ex) begin bad++; $display("FAIL l1_rd0 got=%h exp=%h", rd, ex); end
        total++; if (rn !== 1'b0) begin bad++; $display("FAIL l1_pulse_width got=%b exp=0", rn); end
        run_txn(1, 0, 0, 16'h0010, '0, rel, t2, rd, rn);
        ex = exp_q.pop_front();
        total++; if (t2 - t1 !== 2) begin bad++; $display("FAIL l1_spacing got=%0d exp=2", t2 - t1); end
        total++; if (rd !== ex) begin bad++; $display("FAIL l1_rd1 got=%h exp=%h", rd, ex); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbiter_alternate();
        test_abort();
        test_both_high();
        test_reset_mid_write();
        test_op_change();
        test_latency_one();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL exp_q_drained got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
